// File: rtl/branch_commit_unit.sv
// ---------------------------------------------------------------------------
// branch_commit_unit
//
// Purpose:
//   Takes committed branches from the back end of the pipeline. Every accepted
//   branch goes into a small circular queue and is later handed to the branch
//   predictor as a training update. A branch whose actual outcome differs from
//   its predicted outcome also raises a one-cycle pipeline flush, together with
//   the PC where fetch has to restart.
//
// Optional feature:
//   BCU_STATS_EN - when defined, adds the br_cnt / miss_cnt statistics outputs.
//
// Parameters:
//   FIFO_DEPTH    - update-queue depth (power of two, >= 2)
//
// Ports:
//   clk           - system clock
//   rst_in        - synchronous active-high reset
//   rdy_in        - global enable; all state is held while low
//   commit_en     - a committed branch is offered this cycle
//   commit_pc     - PC of the committed branch
//   commit_taken  - actual branch outcome
//   commit_pred   - outcome predicted at fetch
//   commit_target - branch target address
//   commit_ready  - the unit accepts a commit this cycle
//   upd_en        - predictor update strobe
//   upd_pc        - PC to train
//   upd_jump      - outcome to train
//   flush         - one-cycle pipeline flush on misprediction
//   redirect_pc   - fetch restart PC, valid while flush is high
//   br_cnt        - accepted commits (BCU_STATS_EN only)
//   miss_cnt      - accepted mispredicted commits (BCU_STATS_EN only)
// ---------------------------------------------------------------------------
module branch_commit_unit #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        commit_en,
    input  logic [31:0] commit_pc,
    input  logic        commit_taken,
    input  logic        commit_pred,
    input  logic [31:0] commit_target,
    output logic        commit_ready,
    output logic        upd_en,
    output logic [31:0] upd_pc,
    output logic        upd_jump,
    output logic        flush,
    output logic [31:0] redirect_pc
`ifdef BCU_STATS_EN
    ,
    output logic [31:0] br_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [31:0]      mem_pc_r   [FIFO_DEPTH];
    logic             mem_jump_r [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] cnt_r;
    logic             upd_en_r;
    logic [31:0]      upd_pc_r;
    logic             upd_jump_r;
    logic             flush_r;
    logic [31:0]      redirect_r;

    logic             full_s;
    logic             ready_s;
    logic             accept_s;
    logic             pop_s;
    logic             miss_s;
    logic [31:0]      redirect_next_s;

    // Handshake, pop and misprediction decode from the registered state.
    always_comb begin
        full_s          = 1'b0;
        ready_s         = 1'b0;
        accept_s        = 1'b0;
        pop_s           = 1'b0;
        miss_s          = 1'b0;
        redirect_next_s = 32'h0000_0000;

        // Readiness depends only on the registered count, so a pop in the
        // same cycle can never open room for a push into a full queue.
        full_s   = (cnt_r == DEPTH_C);
        ready_s  = !full_s && !flush_r;
        accept_s = rdy_in && commit_en && ready_s;
        // The pop looks at the count before this cycle's push: no bypass.
        pop_s    = rdy_in && (cnt_r != {CNT_W{1'b0}});
        miss_s   = accept_s && (commit_taken != commit_pred);

        if (commit_taken) begin
            redirect_next_s = commit_target;
        end else begin
            redirect_next_s = commit_pc + 32'd4;
        end
    end

    // Queue storage; contents need no reset because the count guards reads.
    always_ff @(posedge clk) begin
        if (accept_s && !rst_in) begin
            mem_pc_r[wr_ptr_r]   <= commit_pc;
            mem_jump_r[wr_ptr_r] <= commit_taken;
        end
    end

    // Pointers, count, predictor update outputs and flush pulse.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            rd_ptr_r   <= {PTR_W{1'b0}};
            wr_ptr_r   <= {PTR_W{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            upd_en_r   <= 1'b0;
            upd_pc_r   <= 32'h0000_0000;
            upd_jump_r <= 1'b0;
            flush_r    <= 1'b0;
            redirect_r <= 32'h0000_0000;
        end else if (rdy_in) begin
            if (pop_s) begin
                upd_en_r   <= 1'b1;
                upd_pc_r   <= mem_pc_r[rd_ptr_r];
                upd_jump_r <= mem_jump_r[rd_ptr_r];
                rd_ptr_r   <= rd_ptr_r + PTR_W'(1);
            end else begin
                upd_en_r   <= 1'b0;
            end

            if (accept_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end

            case ({accept_s, pop_s})
                2'b10:   cnt_r <= cnt_r + CNT_W'(1);
                2'b01:   cnt_r <= cnt_r - CNT_W'(1);
                default: cnt_r <= cnt_r;
            endcase

            // Flush lasts one enabled cycle; a stall simply stretches it.
            flush_r <= miss_s;
            if (miss_s) begin
                redirect_r <= redirect_next_s;
            end
        end
    end

`ifdef BCU_STATS_EN
    logic [31:0] br_cnt_r;
    logic [31:0] miss_cnt_r;

    // Statistics counters, wrapping naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            br_cnt_r   <= 32'h0000_0000;
            miss_cnt_r <= 32'h0000_0000;
        end else if (rdy_in) begin
            if (accept_s) begin
                br_cnt_r <= br_cnt_r + 32'd1;
            end
            if (miss_s) begin
                miss_cnt_r <= miss_cnt_r + 32'd1;
            end
        end
    end

    assign br_cnt   = br_cnt_r;
    assign miss_cnt = miss_cnt_r;
`endif

    assign commit_ready = ready_s;
    assign upd_en       = upd_en_r;
    assign upd_pc       = upd_pc_r;
    assign upd_jump     = upd_jump_r;
    assign flush        = flush_r;
    assign redirect_pc  = redirect_r;

endmodule
